// File: rtl/mem_defs.sv
// mem_defs: shared size/RW codes, FSM states and lane-steering helpers for ram_handshake_ctrl.
package mem_defs;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
    typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10} state_e;
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;
    localparam int   CNT_W = 4;

    // Lane 0 is the byte at the access address (bits 31:24, big-endian).
    function automatic logic [3:0] lane_mask(size_e sz);
        return sz == SZ_BYTE ? 4'b0001 : sz == SZ_HALF ? 4'b0011 : 4'b1111;
    endfunction

    function automatic logic [31:0] align_wr(logic [31:0] d, size_e sz);
        return sz == SZ_BYTE ? {d[7:0], 24'h0} : sz == SZ_HALF ? {d[15:0], 16'h0} : d;
    endfunction

    function automatic logic [31:0] extend(logic [31:0] lanes, size_e sz, logic sx);
        return sz == SZ_BYTE ? {{24{sx & lanes[31]}}, lanes[31:24]} :
               sz == SZ_HALF ? {{16{sx & lanes[31]}}, lanes[31:16]} : lanes;
    endfunction
endpackage

// File: rtl/byte_ram.sv
// byte_ram: byte array with four big-endian lane read ports at A..A+3 and per-lane synchronous write.
module byte_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [7:0] Mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) Mem[addr + ADDR_W'(i)] <= wdata[31-8*i -: 8];
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign rdata[31-8*i -: 8] = Mem[addr + ADDR_W'(i)];
    end
endmodule

// File: rtl/ram_handshake_ctrl.sv
// ram_handshake_ctrl: byte-addressed RAM behind a four-phase MFA/MFC handshake with
// programmable wait states and byte/halfword/word accesses with optional sign extension.
module ram_handshake_ctrl
    import mem_defs::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              RW_RAM,
    input  logic [1:0]        Size,
    input  logic              SignExt,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              Err,
    output logic              Busy
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    size_e             size_q, size_d;
    logic              rw_q, rw_d, sext_q, sext_d, err_q, err_d;
    logic [31:0]       wdata_q, wdata_d, dout_q, dout_d, rdata;
    logic [3:0]        we;
    logic              bad;

    byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk  (CLK),
        .addr (addr_q),
        .we   (we),
        .wdata(align_wr(wdata_q, size_q)),
        .rdata(rdata)
    );

    assign bad = size_q == SZ_ILL || (size_q == SZ_HALF && addr_q[0]) ||
                 (size_q == SZ_WORD && addr_q[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        rw_d    = rw_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        err_d   = err_q;
        we      = 4'b0000;
        case (state_q)
            IDLE: if (MFA) begin
                addr_d  = Address;
                size_d  = size_e'(Size);
                rw_d    = RW_RAM;
                sext_d  = SignExt;
                wdata_d = DataIn;
                cnt_d   = CNT_W'(WAIT_STATES);
                state_d = ACCESS;
            end
            ACCESS: if (!MFA) state_d = IDLE;
                else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else begin
                    state_d = DONE;
                    err_d   = bad;
                    we      = (!bad && rw_q == WRITE) ? lane_mask(size_q) : 4'b0000;
                    dout_d  = (!bad && rw_q == READ) ? extend(rdata, size_q, sext_q) : dout_q;
                end
            DONE: if (!MFA) begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            rw_q    <= READ;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            sext_q  <= sext_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    assign DataOut = dout_q;
    assign MFC     = state_q == DONE;
    assign Err     = err_q;
    assign Busy    = state_q != IDLE;
endmodule

// File: doc/ram_handshake_ctrl.md
# ram_handshake_ctrl

Parametrised byte-addressed data/instruction RAM with a four-phase MFA/MFC handshake, programmable wait states, and byte/halfword/word access sizes with optional sign extension. It replaces the fixed-latency, word-only RAM inside the datapath. The control unit raises MFA and stalls until MFC. Storage is big-endian: the byte at address A is bits 31:24 of the word at A.

## Interface
Parameters:
- ADDR_W, 8: byte-address width. Depth is 2^ADDR_W bytes.
- WAIT_STATES, 2: extra cycles between accepting a request and completing it (0..15).

Ports:
- CLK  in  1  clock. All state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MFA  in  1  memory function activate (request). Level, held until MFC is seen.
- RW_RAM  in  1  1 = write, 0 = read. Sampled with MFA.
- Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- SignExt  in  1  reads only: 1 sign-extends a byte/halfword, 0 zero-extends.
- Address  in  ADDR_W  byte address.
- DataIn  in  32  write data, right-justified for byte/halfword.
- DataOut  out  32  read data, right-justified and extended.
- MFC  out  1  memory function complete.
- Err  out  1  valid only while MFC=1. Set for a misaligned address or Size=11.
- Busy  out  1  high in ACCESS and DONE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If MFA=1 at an edge, latch Address, Size, RW_RAM, SignExt and DataIn.
  - Load the wait counter with WAIT_STATES and go to ACCESS.
- ACCESS:
  - While the counter is nonzero, decrement it each edge.
  - At the edge where the counter is 0, complete the access, set MFC to 1 and go to DONE.
- Completion:
  - Alignment: halfword needs Address[0]=0. Word needs Address[1:0]=00.
  - Misaligned or Size=11: set Err=1, perform no write, leave DataOut unchanged.
  - Write: store DataIn[7:0], [15:0] or [31:0] big-endian at the latched address.
  - Read: assemble the bytes big-endian, extend according to SignExt, and load DataOut.
- DONE:
  - Hold MFC=1 and Err while MFA=1.
  - At the first edge with MFA=0, clear MFC and Err and return to IDLE.
  - A new request needs MFA to be low for at least one edge (full four-phase handshake).
- Abort: if MFA=0 at any edge in ACCESS, return to IDLE. No write is performed, DataOut is unchanged and MFC never rises.
- No address wrap-around: aligned accesses always fit inside the array.
- Inputs other than MFA are ignored after the request is latched.

## Timing
- Reset (asynchronous, Reset=0): state IDLE, MFC=0, Err=0, Busy=0, DataOut=0, counter=0.
  - The memory array is not cleared.
  - A reset during ACCESS cancels the access with no write.
- Latency: request accepted at edge E0, MFC=1 after edge E0+WAIT_STATES+1.
  - WAIT_STATES=0 gives MFC one cycle after acceptance.
- A write is visible to a read that is accepted after the write's MFC.
- MFC and Err fall after the first edge at which DONE samples MFA=0.
- Busy rises after E0 and falls together with MFC.

## Structure
- Shared definitions file mem_defs, holding:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - RW codes READ=1'b0, WRITE=1'b1;
  - FSM state encodings.
- Sub-module byte_ram (ADDR_W): byte array with four byte-lane read ports and write enables at A..A+3, synchronous write.
  - The testbench preload uses the hierarchical path to its Mem array.
- Top level: FSM, wait counter, request latch, alignment check, big-endian lane steering and extension logic.

## Test plan
- Word write then read, WAIT_STATES=2:
  - Write 0xDEADBEEF to address 0x10. Read 0x10 with Size=10: DataOut=0xDEADBEEF.
  - MFC rises after the 3rd edge following acceptance.
  - Byte reads of 0x10..0x13 return 0xDE, 0xAD, 0xBE, 0xEF.
- Extension:
  - Mem[0x20..0x21]=0x80,0x7F.
  - Halfword read of 0x20 with SignExt=1 gives 0xFFFF807F. With SignExt=0 it gives 0x0000807F.
  - Byte read of 0x21 with SignExt=1 gives 0x0000007F.
- Misalignment:
  - Word write to 0x22 gives Err=1 with MFC, and memory is unchanged.
  - Halfword read of 0x21 gives Err=1, and DataOut keeps its previous value.
  - Size=11 gives Err=1.
- Handshake:
  - MFA held high for 5 cycles after MFC: MFC stays high and no second access occurs.
  - MFA dropped for one edge then raised: a new access starts.
  - WAIT_STATES=0: MFC rises one cycle after acceptance.
- Abort and reset:
  - MFA dropped during ACCESS of a write of 0x12345678 to 0x40: no MFC, and Mem[0x40..0x43] is unchanged.
  - Reset pulled low mid-ACCESS: MFC=0, Busy=0, DataOut=0 immediately, and the memory contents are preserved.
- Boundary: word write and read at 0xFC (ADDR_W=8) complete normally with Err=0.
